pipeline_stall_ctrl: RTL and testbench

// Consumer of the hazard unit's stall/flush requests. Turns them into per-stage enable/bubble controls for the PC, IF/EX and EX/WB registers of the 3-stage pipeline.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 13 +
 rtl/pipeline_stall_ctrl_sat_counter.sv | 20 ++
 rtl/pipeline_stall_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions for the 3-stage core.
// Stall controller state encoding and the canonical NOP.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FLUSH
  } stall_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter for pipeline performance stats.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns hazard stall/flush requests and dmem wait states
// into per-stage enable/bubble controls for the pipeline.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_ex_en,
  output logic             if_ex_bubble,
  output logic             ex_wb_en,
  output logic             ex_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [1:0] FC_INIT = 2'(FLUSH_CYCLES - 1);

  stall_state_e    state_q;
  logic [1:0]      fc_q;
  logic [WC_W-1:0] wc_q;
  logic            mem_err_q;
  logic            mem_go;
  logic            flush_acc;

  assign mem_go  = dmem_req && !dmem_ack;
  assign mem_err = mem_err_q;

  always_comb begin
    pc_en        = 1'b1;
    if_ex_en     = 1'b1;
    if_ex_bubble = 1'b0;
    ex_wb_en     = 1'b1;
    ex_wb_bubble = 1'b0;
    flush_acc    = 1'b0;
    priority case (1'b1)
      rst: begin
        pc_en        = 1'b0;
        if_ex_en     = 1'b0;
        ex_wb_en     = 1'b0;
        if_ex_bubble = 1'b1;
        ex_wb_bubble = 1'b1;
      end
      (state_q == MEM_WAIT) || mem_go: begin
        pc_en    = 1'b0;
        if_ex_en = 1'b0;
        ex_wb_en = 1'b0;
      end
      state_q == FLUSH: begin
        if_ex_bubble = 1'b1;
      end
      stall_req: begin
        pc_en        = 1'b0;
        if_ex_en     = 1'b0;
        ex_wb_bubble = 1'b1;
      end
      flush_req: begin
        if_ex_bubble = 1'b1;
        flush_acc    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      fc_q      <= '0;
      wc_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (mem_go) begin
            state_q <= MEM_WAIT;
            wc_q    <= WC_W'(1);
          end else if (flush_acc && (FLUSH_CYCLES > 1)) begin
            state_q <= FLUSH;
            fc_q    <= FC_INIT;
          end
        end
        FLUSH: begin
          // freeze keeps the remaining flush count for after the ack
          if (mem_go) begin
            state_q <= MEM_WAIT;
            wc_q    <= WC_W'(1);
          end else if (fc_q <= 2'd1) begin
            state_q <= RUN;
            fc_q    <= '0;
          end else begin
            fc_q <= fc_q - 2'd1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack || !dmem_req) begin
            wc_q    <= '0;
            state_q <= (fc_q != '0) ? FLUSH : RUN;
          end else if (wc_q == WC_LAST) begin
            mem_err_q <= 1'b1;
            wc_q      <= '0;
            fc_q      <= '0;
            state_q   <= RUN;
          end else begin
            wc_q <= wc_q + 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!pc_en && !rst),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_acc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl.
// Second narrow-counter instance covers saturation.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_req = 1'b0;
  logic flush_req = 1'b0;
  logic dmem_req = 1'b0;
  logic dmem_ack = 1'b0;
  logic pc_en, if_ex_en, if_ex_bubble;
  logic ex_wb_en, ex_wb_bubble, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  logic s2_stall = 1'b0;
  logic s2_flush = 1'b0;
  logic s2_pc_en, s2_if_ex_en, s2_if_ex_bubble;
  logic s2_ex_wb_en, s2_ex_wb_bubble, s2_mem_err;
  logic [1:0] s2_stall_cnt, s2_flush_cnt;

  int checks = 0;
  int failures = 0;

  logic [4:0] ctl;
  assign ctl = {pc_en, if_ex_en, if_ex_bubble, ex_wb_en, ex_wb_bubble};

  localparam logic [4:0] C_IDLE  = 5'b11010;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_FRZ   = 5'b00000;
  localparam logic [4:0] C_RST   = 5'b00101;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .FLUSH_CYCLES(2), .TIMEOUT(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .stall_req(stall_req), .flush_req(flush_req),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .if_ex_en(if_ex_en),
    .if_ex_bubble(if_ex_bubble), .ex_wb_en(ex_wb_en),
    .ex_wb_bubble(ex_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_stall_ctrl #(
    .FLUSH_CYCLES(1), .TIMEOUT(4), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .stall_req(s2_stall), .flush_req(s2_flush),
    .dmem_req(1'b0), .dmem_ack(1'b0),
    .pc_en(s2_pc_en), .if_ex_en(s2_if_ex_en),
    .if_ex_bubble(s2_if_ex_bubble), .ex_wb_en(s2_ex_wb_en),
    .ex_wb_bubble(s2_ex_wb_bubble), .mem_err(s2_mem_err),
    .stall_cnt(s2_stall_cnt), .flush_cnt(s2_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    tick();
    tick();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    rst = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
    tick();

    // load-use stall
    stall_req = 1'b1;
    #1;
    chk("stall_ctl", 32'(ctl), 32'(C_STALL));
    tick();
    stall_req = 1'b0;
    #1;
    chk("stall_cnt1", stall_cnt, 1);
    chk("stall_after", 32'(ctl), 32'(C_IDLE));
    tick();

    // branch flush, two squash cycles
    flush_req = 1'b1;
    #1;
    chk("flush_c0", 32'(ctl), 32'(C_FLUSH));
    tick();
    flush_req = 1'b0;
    #1;
    chk("flush_c1", 32'(ctl), 32'(C_FLUSH));
    chk("flush_cnt1", flush_cnt, 1);
    tick();
    #1;
    chk("flush_done", 32'(ctl), 32'(C_IDLE));
    tick();

    // wait states: ack on the fourth frozen cycle
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      chk($sformatf("wait_frz%0d", i), 32'(ctl), 32'(C_FRZ));
      chk($sformatf("wait_err%0d", i), 32'(mem_err), 0);
      tick();
    end
    dmem_req = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("wait_stall_cnt", stall_cnt, 5);
    chk("wait_no_err", 32'(mem_err), 0);
    chk("wait_resume", 32'(ctl), 32'(C_IDLE));
    tick();

    // timeout with no ack
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_frz%0d", i), 32'(ctl), 32'(C_FRZ));
      chk($sformatf("to_err%0d", i), 32'(mem_err), 0);
      tick();
    end
    dmem_req = 1'b0;
    #1;
    chk("to_err_pulse", 32'(mem_err), 1);
    chk("to_run", 32'(ctl), 32'(C_IDLE));
    chk("to_stall_cnt", stall_cnt, 9);
    tick();
    #1;
    chk("to_err_clear", 32'(mem_err), 0);
    tick();

    // stall and flush together
    stall_req = 1'b1;
    flush_req = 1'b1;
    #1;
    chk("coll_ctl", 32'(ctl), 32'(C_STALL));
    tick();
    stall_req = 1'b0;
    flush_req = 1'b0;
    #1;
    chk("coll_flush_cnt", flush_cnt, 1);
    chk("coll_stall_cnt", stall_cnt, 10);
    chk("coll_after", 32'(ctl), 32'(C_IDLE));
    tick();

    // freeze preempts FLUSH, flush resumes after ack
    flush_req = 1'b1;
    #1;
    chk("ff_c0", 32'(ctl), 32'(C_FLUSH));
    tick();
    flush_req = 1'b0;
    dmem_req = 1'b1;
    #1;
    chk("ff_frz0", 32'(ctl), 32'(C_FRZ));
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("ff_frz1", 32'(ctl), 32'(C_FRZ));
    tick();
    dmem_req = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("ff_resume", 32'(ctl), 32'(C_FLUSH));
    tick();
    #1;
    chk("ff_done", 32'(ctl), 32'(C_IDLE));
    chk("ff_flush_cnt", flush_cnt, 2);
    chk("ff_stall_cnt", stall_cnt, 12);
    tick();

    // reset in the middle of MEM_WAIT
    dmem_req = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rmw_ctl", 32'(ctl), 32'(C_RST));
    tick();
    rst = 1'b0;
    dmem_req = 1'b0;
    #1;
    chk("rmw_run", 32'(ctl), 32'(C_IDLE));
    chk("rmw_stall_cnt", stall_cnt, 0);
    chk("rmw_flush_cnt", flush_cnt, 0);
    tick();
    #1;
    chk("rmw_still_run", 32'(ctl), 32'(C_IDLE));

    // saturation on the 2-bit counters
    s2_stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("sat_stall_top", 32'(s2_stall_cnt), 3);
    tick();
    tick();
    chk("sat_stall_hold", 32'(s2_stall_cnt), 3);
    s2_stall = 1'b0;
    s2_flush = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_flush_hold", 32'(s2_flush_cnt), 3);
    s2_flush = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
